// File: rtl/seq_add_mult.sv
// seq_add_mult: single-request add / multiply unit with valid/ready handshakes.
//   Add completes in one cycle. Multiply runs a shift-add loop with one
//   iteration per cycle for exactly WIDTH cycles, whatever the operand values.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   in_valid   : request valid
//   in_ready   : request accepted this cycle (high only in IDLE, low in reset)
//   op         : 0 = add, 1 = multiply
//   a, b       : unsigned operands, WIDTH bits
//   out_valid  : result valid (DONE only)
//   out_ready  : consumer takes the result
//   result     : unsigned result, 2*WIDTH bits, forced to 0 when out_valid is low
//   busy       : state is not IDLE
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// MUL   | shift-add iterations in progress
// DONE  | result presented, waiting for out_ready
module seq_add_mult #(
    parameter int WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    // Outputs are gated by rst so the block looks idle-but-unavailable while
    // reset is held, independent of whatever state precedes the first edge.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE) && !rst;
    assign busy      = (state_q != IDLE) && !rst;
    assign result    = out_valid ? acc_q : '0;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    // The chosen next state records op for the whole operation.
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    cnt_d    = '0;
                    if (op) begin
                        acc_d   = '0;
                        state_d = MUL;
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, a} + {{WIDTH{1'b0}}, b};
                        state_d = DONE;
                    end
                end
            end
            MUL: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // No early exit on a zero multiplier: latency is always WIDTH.
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_seq_add_mult.sv
// Bench for seq_add_mult: one WIDTH=3 and one WIDTH=8 instance share the
// stimulus bus; 'sel' picks which one receives in_valid and is observed.
module tb_seq_add_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        op;
    logic [7:0]  a, b;
    logic        out_ready;
    logic        sel;

    logic        ir3, ov3, busy3;
    logic [5:0]  res3;
    logic        ir8, ov8, busy8;
    logic [15:0] res8;

    logic        iv3, iv8;
    logic        in_ready_s, out_valid_s, busy_s;
    logic [15:0] result_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign iv3 = in_valid && !sel;
    assign iv8 = in_valid && sel;

    assign in_ready_s  = sel ? ir8   : ir3;
    assign out_valid_s = sel ? ov8   : ov3;
    assign busy_s      = sel ? busy8 : busy3;
    assign result_s    = sel ? res8  : {10'd0, res3};

    seq_add_mult #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .op(op),
        .a(a[2:0]), .b(b[2:0]), .out_valid(ov3), .out_ready(out_ready),
        .result(res3), .busy(busy3)
    );

    seq_add_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .op(op),
        .a(a), .b(b), .out_valid(ov8), .out_ready(out_ready),
        .result(res8), .busy(busy8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: add -> a+b after 1 cycle; mul -> a*b after WIDTH+1 cycles.
    task automatic do_op(input bit s, input bit o, input int av, input int bv, input int hold);
        int w, exp_r, exp_lat, lat;
        w       = s ? 8 : 3;
        exp_r   = o ? av * bv : av + bv;
        exp_lat = o ? w + 1 : 1;
        @(negedge clk);
        sel = s;
        #1;
        chk("in_ready_idle", in_ready_s, 1);
        chk("busy_idle", busy_s, 0);
        in_valid  = 1'b1;
        op        = o;
        a         = av[7:0];
        b         = bv[7:0];
        out_ready = (hold == 0);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid_s && lat < 40) begin
            chk("busy_mul", busy_s, 1);
            chk("in_ready_mul", in_ready_s, 0);
            chk("result_zero_mul", result_s, 0);
            // In-flight operands must be immune to bus activity.
            a        = $urandom;
            b        = $urandom;
            op       = $urandom;
            in_valid = $urandom;
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("result", result_s, exp_r);
        chk("busy_done", busy_s, 1);
        chk("in_ready_done", in_ready_s, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", out_valid_s, 1);
            chk("hold_result", result_s, exp_r);
            chk("hold_in_ready", in_ready_s, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("after_valid", out_valid_s, 0);
        chk("after_in_ready", in_ready_s, 1);
        chk("after_result", result_s, 0);
        chk("after_busy", busy_s, 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = 1'b0; a = '0; b = '0;
        out_ready = 1'b0; sel = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready3", ir3, 0);
        chk("rst_in_ready8", ir8, 0);
        chk("rst_valid3", ov3, 0);
        chk("rst_busy8", busy8, 0);
        chk("rst_result3", res3, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready3", ir3, 1);
        chk("post_rst_in_ready8", ir8, 1);

        // Directed cases for the narrow instance.
        do_op(0, 0, 7, 7, 0);
        do_op(0, 1, 7, 7, 0);
        do_op(0, 1, 5, 6, 10);
        do_op(0, 1, 6, 0, 0);
        do_op(0, 1, 0, 7, 2);
        do_op(0, 0, 0, 0, 1);

        // Reset two cycles after accepting 3*3.
        @(negedge clk);
        sel = 1'b0; in_valid = 1'b1; op = 1'b1; a = 8'd3; b = 8'd3; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1; op = 1'b1; a = 8'd2; b = 8'd2;
        #1;
        chk("midrst_valid", ov3, 0);
        chk("midrst_result", res3, 0);
        chk("midrst_busy", busy3, 0);
        chk("midrst_in_ready", ir3, 0);
        repeat (2) @(negedge clk);
        chk("inrst_busy", busy3, 0);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("postrst_busy", busy3, 0);
        chk("postrst_valid", ov3, 0);
        do_op(0, 0, 1, 2, 0);

        // Directed cases for the wide instance.
        do_op(1, 1, 255, 255, 0);
        do_op(1, 0, 255, 1, 0);
        do_op(1, 1, 0, 255, 3);

        // Randomized traffic on both instances.
        for (int i = 0; i < 40; i++) begin
            bit s;
            int wmax;
            s    = $urandom_range(0, 1);
            wmax = s ? 255 : 7;
            do_op(s, $urandom_range(0, 1), $urandom_range(0, wmax),
                  $urandom_range(0, wmax), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
